// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit. Issues one read per instruction on an AXI-lite style
// read channel, waits (bounded) for the response, presents the instruction to
// the decode stage and then parks until the writeback stage retires it and
// supplies the next PC.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   i_ifu_npc        next PC from the branch unit
//   i_ifu_npc_wen    retire strobe; loads i_ifu_npc (only honoured in S_HOLD)
//   o_ifu_araddr     read address (equals the current PC)
//   o_ifu_arvalid    read address valid
//   i_ifu_arready    read address ready
//   i_ifu_rdata      read data
//   i_ifu_rresp      read response, 2'b00 = OKAY
//   i_ifu_rvalid     read data valid
//   o_ifu_rready     read data ready (high only while waiting for data)
//   o_ifu_inst       fetched instruction
//   o_ifu_pc         PC of o_ifu_inst
//   o_ifu_valid      instruction valid to the decode stage
//   i_ifu_ready      decode stage accept
//   o_ifu_fault      fetch fault for the presented instruction (0 when !valid)
// ----------------------------------------------------------------------------
module ifu_fetch #(
   parameter int                   CPU_Width    = 32,
   parameter logic [CPU_Width-1:0] RESET_VECTOR = 32'h8000_0000,
   parameter int                   TIMEOUT      = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CPU_Width-1:0] i_ifu_npc,
   input  logic                 i_ifu_npc_wen,
   output logic [CPU_Width-1:0] o_ifu_araddr,
   output logic                 o_ifu_arvalid,
   input  logic                 i_ifu_arready,
   input  logic [31:0]          i_ifu_rdata,
   input  logic [1:0]           i_ifu_rresp,
   input  logic                 i_ifu_rvalid,
   output logic                 o_ifu_rready,
   output logic [31:0]          o_ifu_inst,
   output logic [CPU_Width-1:0] o_ifu_pc,
   output logic                 o_ifu_valid,
   input  logic                 i_ifu_ready,
   output logic                 o_ifu_fault
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   // The wait counter is 8 bits wide, so the usable timeout is clamped to
   // 1..256 cycles. The counter starts at 0 on the first S_WAIT cycle, so
   // giving up when it reads TIMEOUT-1 bounds the wait to TIMEOUT cycles.
   localparam int            TO_EFF   = (TIMEOUT < 1) ? 1 : ((TIMEOUT > 256) ? 256 : TIMEOUT);
   localparam logic [7:0]    CNT_LAST = 8'(TO_EFF - 1);

   state_t               state_reg;
   logic [CPU_Width-1:0] pc_reg;
   logic [31:0]          inst_reg;
   logic                 fault_reg;
   logic                 valid_reg;
   logic                 arvalid_reg;
   logic                 rready_reg;
   logic [7:0]           cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_REQ;
         pc_reg      <= RESET_VECTOR;
         inst_reg    <= 32'h0;
         fault_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         arvalid_reg <= 1'b0;
         rready_reg  <= 1'b0;
         cnt_reg     <= 8'h0;
      end else begin
         case (state_reg)
            S_REQ: begin
               // Out of reset arvalid is still low; raise it on the first
               // edge. From S_HOLD it is already raised on the way in.
               if (!arvalid_reg) begin
                  arvalid_reg <= 1'b1;
               end else if (i_ifu_arready) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  cnt_reg     <= 8'h0;
                  state_reg   <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (cnt_reg != 8'hFF) begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
               if (i_ifu_rvalid) begin
                  inst_reg   <= i_ifu_rdata;
                  fault_reg  <= (i_ifu_rresp != 2'b00);
                  valid_reg  <= 1'b1;
                  rready_reg <= 1'b0;
                  state_reg  <= S_OUT;
               end else if (cnt_reg == CNT_LAST) begin
                  inst_reg   <= 32'h0;
                  fault_reg  <= 1'b1;
                  valid_reg  <= 1'b1;
                  rready_reg <= 1'b0;
                  state_reg  <= S_OUT;
               end
            end

            S_OUT: begin
               if (i_ifu_ready) begin
                  // Fault is only meaningful alongside valid, drop both.
                  valid_reg <= 1'b0;
                  fault_reg <= 1'b0;
                  state_reg <= S_HOLD;
               end
            end

            S_HOLD: begin
               if (i_ifu_npc_wen) begin
                  pc_reg <= i_ifu_npc;
                  if (i_ifu_npc[1:0] == 2'b00) begin
                     arvalid_reg <= 1'b1;
                     state_reg   <= S_REQ;
                  end else begin
                     // Misaligned target: report the fault without touching
                     // the bus.
                     inst_reg  <= 32'h0;
                     fault_reg <= 1'b1;
                     valid_reg <= 1'b1;
                     state_reg <= S_OUT;
                  end
               end
            end

            default: begin
               state_reg <= S_REQ;
            end
         endcase
      end
   end

   assign o_ifu_araddr  = pc_reg;
   assign o_ifu_arvalid = arvalid_reg;
   assign o_ifu_rready  = rready_reg;
   assign o_ifu_inst    = inst_reg;
   assign o_ifu_pc      = pc_reg;
   assign o_ifu_valid   = valid_reg;
   assign o_ifu_fault   = fault_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
// Scenario-per-task bench for ifu_fetch. A small transaction model tracks the
// architectural PC and, for each fetch, what the decode stage must see given
// the response the bench chose to return (data, error, silence, misaligned
// target). Bus/decode driving tasks only move handshakes and report what they
// observed; every comparison lives in the scenario tasks.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam int          W   = 32;
   localparam logic [31:0] RV  = 32'h8000_0000;
   localparam int          TMO = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  i_ifu_npc = '0;
   logic          i_ifu_npc_wen = 1'b0;
   logic [W-1:0]  o_ifu_araddr;
   logic          o_ifu_arvalid;
   logic          i_ifu_arready = 1'b0;
   logic [31:0]   i_ifu_rdata = 32'h0;
   logic [1:0]    i_ifu_rresp = 2'b00;
   logic          i_ifu_rvalid = 1'b0;
   logic          o_ifu_rready;
   logic [31:0]   o_ifu_inst;
   logic [W-1:0]  o_ifu_pc;
   logic          o_ifu_valid;
   logic          i_ifu_ready = 1'b0;
   logic          o_ifu_fault;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [31:0] m_pc;   // model: architectural PC

   ifu_fetch #(.CPU_Width(W), .RESET_VECTOR(RV), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_ifu_npc(i_ifu_npc), .i_ifu_npc_wen(i_ifu_npc_wen),
      .o_ifu_araddr(o_ifu_araddr), .o_ifu_arvalid(o_ifu_arvalid), .i_ifu_arready(i_ifu_arready),
      .i_ifu_rdata(i_ifu_rdata), .i_ifu_rresp(i_ifu_rresp), .i_ifu_rvalid(i_ifu_rvalid),
      .o_ifu_rready(o_ifu_rready),
      .o_ifu_inst(o_ifu_inst), .o_ifu_pc(o_ifu_pc), .o_ifu_valid(o_ifu_valid),
      .i_ifu_ready(i_ifu_ready), .o_ifu_fault(o_ifu_fault)
   );

   always #5 clk = ~clk;

   // Advance one clock; everything is sampled and driven 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Serve one read: wait for arvalid, stall arready for ar_wait cycles, then
   // handshake; optionally return data after r_wait cycles; then wait for
   // valid. lat = edges from the address handshake to valid.
   task automatic serve_fetch(input int ar_wait, input int r_wait, input logic [31:0] data,
                              input logic [1:0] resp, input bit respond,
                              output logic [31:0] addr_seen, output bit stable,
                              output bit rready_ok, output int lat, output bit ok);
      int n;
      int hs_cyc;
      ok = 1'b1; stable = 1'b1; rready_ok = 1'b1; lat = -1; addr_seen = 32'hx;
      n = 0;
      while (o_ifu_arvalid !== 1'b1 && n < 20) begin step(); n++; end
      if (o_ifu_arvalid !== 1'b1) begin ok = 1'b0; return; end
      addr_seen = o_ifu_araddr;
      if (o_ifu_rready !== 1'b0) rready_ok = 1'b0;
      repeat (ar_wait) begin
         step();
         if (o_ifu_arvalid !== 1'b1 || o_ifu_araddr !== addr_seen) stable = 1'b0;
      end
      i_ifu_arready = 1'b1;
      step();
      i_ifu_arready = 1'b0;
      hs_cyc = cyc;
      if (o_ifu_rready !== 1'b1 || o_ifu_arvalid !== 1'b0) rready_ok = 1'b0;
      if (respond) begin
         repeat (r_wait) step();
         i_ifu_rvalid = 1'b1; i_ifu_rdata = data; i_ifu_rresp = resp;
         step();
         i_ifu_rvalid = 1'b0; i_ifu_rdata = $urandom; i_ifu_rresp = 2'b00;
      end
      n = 0;
      while (o_ifu_valid !== 1'b1 && n < 400) begin step(); n++; end
      if (o_ifu_valid !== 1'b1) ok = 1'b0;
      lat = cyc - hs_cyc;
   endtask

   // Hold ready low for 'delay' cycles (optionally pulsing a stray npc_wen),
   // reporting whether the presented instruction stayed put, then accept it.
   task automatic accept(input int delay, input bit stray, output bit stable);
      logic [31:0] ins, p;
      logic        f;
      ins = o_ifu_inst; p = o_ifu_pc; f = o_ifu_fault;
      stable = 1'b1;
      repeat (delay) begin
         if (stray) begin i_ifu_npc_wen = 1'b1; i_ifu_npc = $urandom & 32'hFFFF_FFFC; end
         step();
         i_ifu_npc_wen = 1'b0;
         if (o_ifu_valid !== 1'b1 || o_ifu_inst !== ins || o_ifu_pc !== p || o_ifu_fault !== f)
            stable = 1'b0;
      end
      i_ifu_ready = 1'b1;
      step();
      i_ifu_ready = 1'b0;
   endtask

   task automatic retire(input logic [31:0] npc);
      i_ifu_npc = npc; i_ifu_npc_wen = 1'b1;
      step();
      i_ifu_npc_wen = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      #2 rst = 1'b1;
      #1;  // before any clock edge: reset must act asynchronously
      checks++;
      if (o_ifu_arvalid !== 1'b0 || o_ifu_valid !== 1'b0 || o_ifu_rready !== 1'b0 ||
          o_ifu_fault !== 1'b0 || o_ifu_inst !== 32'h0 || o_ifu_pc !== RV)
         begin errors++; $display("FAIL reset_async: arvalid=%b valid=%b rready=%b fault=%b inst=%h pc=%h, want 0 0 0 0 00000000 %h",
                                  o_ifu_arvalid, o_ifu_valid, o_ifu_rready, o_ifu_fault, o_ifu_inst, o_ifu_pc, RV); end
      repeat (3) step();
      checks++;
      if (o_ifu_arvalid !== 1'b0 || o_ifu_valid !== 1'b0)
         begin errors++; $display("FAIL reset_held: arvalid=%b valid=%b, want 0 0", o_ifu_arvalid, o_ifu_valid); end
      rst = 1'b0;
      #1;
      checks++;
      if (o_ifu_arvalid !== 1'b0)
         begin errors++; $display("FAIL reset_release_arvalid: got %b want 0 before first edge", o_ifu_arvalid); end
      step();
      checks++;
      if (o_ifu_arvalid !== 1'b1 || o_ifu_araddr !== RV || o_ifu_rready !== 1'b0)
         begin errors++; $display("FAIL reset_first_req: arvalid=%b araddr=%h rready=%b, want 1 %h 0",
                                  o_ifu_arvalid, o_ifu_araddr, o_ifu_rready, RV); end
      m_pc = RV;
      $display("reset: pc=%h arvalid=%b", o_ifu_pc, o_ifu_arvalid);
   endtask

   task automatic test_basic();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      serve_fetch(0, 0, 32'h0000_0013, 2'b00, 1'b1, a, st, rr, lat, ok);
      checks++;
      if (!ok || a !== m_pc || lat != 1 || o_ifu_inst !== 32'h0000_0013 || o_ifu_pc !== m_pc || o_ifu_fault !== 1'b0 || !rr)
         begin errors++; $display("FAIL basic_fetch: ok=%0d araddr=%h lat=%0d inst=%h pc=%h fault=%b rready_ok=%0d, want 1 %h 1 00000013 %h 0 1",
                                  ok, a, lat, o_ifu_inst, o_ifu_pc, o_ifu_fault, rr, m_pc, m_pc); end
      accept(0, 1'b0, acc);
      checks++;
      if (o_ifu_valid !== 1'b0 || o_ifu_fault !== 1'b0)
         begin errors++; $display("FAIL basic_accept: valid=%b fault=%b, want 0 0", o_ifu_valid, o_ifu_fault); end
      $display("basic: addr=%h inst=%h lat=%0d", a, o_ifu_inst, lat);
      m_pc = m_pc + 32'd4;
      retire(m_pc);
   endtask

   task automatic test_ar_stall();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      serve_fetch(5, 0, 32'h1234_5678, 2'b00, 1'b1, a, st, rr, lat, ok);
      checks++;
      if (!ok || !st || !rr || a !== m_pc || lat != 1 || o_ifu_inst !== 32'h1234_5678)
         begin errors++; $display("FAIL ar_stall: ok=%0d stable=%0d rready_ok=%0d araddr=%h lat=%0d inst=%h, want 1 1 1 %h 1 12345678",
                                  ok, st, rr, a, lat, o_ifu_inst, m_pc); end
      $display("ar_stall: addr=%h stable=%0d", a, st);
      accept(0, 1'b0, acc);
      m_pc = m_pc + 32'd4;
      retire(m_pc);
   endtask

   task automatic test_out_stall();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      serve_fetch(0, 2, 32'hCAFE_0093, 2'b00, 1'b1, a, st, rr, lat, ok);
      accept(4, 1'b0, acc);
      checks++;
      if (!ok || !acc || lat != 3)
         begin errors++; $display("FAIL out_stall: ok=%0d stable=%0d lat=%0d, want 1 1 3", ok, acc, lat); end
      m_pc = 32'h8000_0010;
      retire(m_pc);
      serve_fetch(0, 0, 32'h0000_0517, 2'b00, 1'b1, a, st, rr, lat, ok);
      checks++;
      if (!ok || a !== 32'h8000_0010 || o_ifu_pc !== 32'h8000_0010)
         begin errors++; $display("FAIL out_stall_npc: ok=%0d araddr=%h pc=%h, want 1 80000010 80000010", ok, a, o_ifu_pc); end
      $display("out_stall: next addr=%h", a);
      accept(0, 1'b0, acc);
      m_pc = m_pc + 32'd4;
      retire(m_pc);
   endtask

   task automatic test_err_resp();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      serve_fetch(1, 1, 32'hDEAD_BEEF, 2'b10, 1'b1, a, st, rr, lat, ok);
      checks++;
      if (!ok || o_ifu_valid !== 1'b1 || o_ifu_fault !== 1'b1 || o_ifu_inst !== 32'hDEAD_BEEF || o_ifu_pc !== m_pc)
         begin errors++; $display("FAIL err_resp: ok=%0d valid=%b fault=%b inst=%h pc=%h, want 1 1 1 deadbeef %h",
                                  ok, o_ifu_valid, o_ifu_fault, o_ifu_inst, o_ifu_pc, m_pc); end
      $display("err_resp: addr=%h fault=%b", a, o_ifu_fault);
      accept(1, 1'b0, acc);
      checks++;
      if (o_ifu_fault !== 1'b0)
         begin errors++; $display("FAIL err_fault_clear: fault=%b want 0 after accept", o_ifu_fault); end
      m_pc = m_pc + 32'd4;
      retire(m_pc);
   endtask

   task automatic test_timeout();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      serve_fetch(0, 0, 32'h0, 2'b00, 1'b0, a, st, rr, lat, ok);
      checks++;
      if (!ok || lat != TMO || o_ifu_fault !== 1'b1 || o_ifu_inst !== 32'h0 || o_ifu_pc !== m_pc || o_ifu_rready !== 1'b0)
         begin errors++; $display("FAIL timeout: ok=%0d wait=%0d fault=%b inst=%h pc=%h rready=%b, want 1 %0d 1 00000000 %h 0",
                                  ok, lat, o_ifu_fault, o_ifu_inst, o_ifu_pc, o_ifu_rready, TMO, m_pc); end
      // A response arriving after the timeout must not disturb the result.
      i_ifu_rvalid = 1'b1; i_ifu_rdata = 32'h5555_AAAA;
      step();
      i_ifu_rvalid = 1'b0;
      checks++;
      if (o_ifu_inst !== 32'h0 || o_ifu_valid !== 1'b1)
         begin errors++; $display("FAIL timeout_late_rvalid: inst=%h valid=%b, want 00000000 1", o_ifu_inst, o_ifu_valid); end
      $display("timeout: addr=%h waited=%0d", a, lat);
      accept(0, 1'b0, acc);
      m_pc = m_pc + 32'd4;
      retire(m_pc);
   endtask

   task automatic test_misaligned();
      logic [31:0] a; bit st, rr, ok, acc; int lat;
      bit pulse;
      serve_fetch(0, 0, 32'h0000_0013, 2'b00, 1'b1, a, st, rr, lat, ok);
      accept(0, 1'b0, acc);
      m_pc = 32'h8000_0002;
      retire(m_pc);
      pulse = (o_ifu_arvalid !== 1'b0);
      checks++;
      if (o_ifu_valid !== 1'b1 || o_ifu_fault !== 1'b1 || o_ifu_inst !== 32'h0 || o_ifu_pc !== 32'h8000_0002)
         begin errors++; $display("FAIL misaligned: valid=%b fault=%b inst=%h pc=%h, want 1 1 00000000 80000002",
                                  o_ifu_valid, o_ifu_fault, o_ifu_inst, o_ifu_pc); end
      repeat (3) begin step(); if (o_ifu_arvalid !== 1'b0) pulse = 1'b1; end
      checks++;
      if (pulse)
         begin errors++; $display("FAIL misaligned_no_req: arvalid pulsed, want none"); end
      $display("misaligned: pc=%h fault=%b", o_ifu_pc, o_ifu_fault);
      accept(0, 1'b0, acc);
      m_pc = 32'h8000_0020;
      retire(m_pc);
   endtask

   task automatic test_reset_midwait();
      int n;
      n = 0;
      while (o_ifu_arvalid !== 1'b1 && n < 20) begin step(); n++; end
      i_ifu_arready = 1'b1;
      step();
      i_ifu_arready = 1'b0;
      step();
      rst = 1'b1;
      i_ifu_rvalid = 1'b1; i_ifu_rdata = 32'h0BAD_0BAD; i_ifu_rresp = 2'b00;
      step(); step();
      rst = 1'b0;
      step();                      // first edge after release, rvalid still high
      i_ifu_rvalid = 1'b0;
      checks++;
      if (o_ifu_valid !== 1'b0 || o_ifu_rready !== 1'b0 || o_ifu_arvalid !== 1'b1 || o_ifu_araddr !== RV || o_ifu_inst !== 32'h0)
         begin errors++; $display("FAIL reset_midwait: valid=%b rready=%b arvalid=%b araddr=%h inst=%h, want 0 0 1 %h 00000000",
                                  o_ifu_valid, o_ifu_rready, o_ifu_arvalid, o_ifu_araddr, o_ifu_inst, RV); end
      m_pc = RV;
      $display("reset_midwait: araddr=%h", o_ifu_araddr);
   endtask

   task automatic test_random();
      logic [31:0] a, d, npc; logic [1:0] rs; bit st, rr, ok, acc; int lat, ar_w, r_w;
      for (int k = 0; k < 25; k++) begin
         ar_w = $urandom_range(0, 3);
         r_w  = $urandom_range(0, 4);
         d    = $urandom;
         rs   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         serve_fetch(ar_w, r_w, d, rs, 1'b1, a, st, rr, lat, ok);
         checks++;
         if (!ok || !st || !rr || a !== m_pc || lat != r_w + 1 || o_ifu_inst !== d ||
             o_ifu_pc !== m_pc || o_ifu_fault !== (rs != 2'b00))
            begin errors++; $display("FAIL rand_fetch[%0d]: ok=%0d st=%0d rr=%0d addr=%h lat=%0d inst=%h pc=%h fault=%b, want addr=%h lat=%0d inst=%h fault=%b",
                                     k, ok, st, rr, a, lat, o_ifu_inst, o_ifu_pc, o_ifu_fault, m_pc, r_w + 1, d, (rs != 2'b00)); end
         accept($urandom_range(0, 3), 1'b1, acc);
         checks++;
         if (!acc || o_ifu_pc !== m_pc || o_ifu_valid !== 1'b0)
            begin errors++; $display("FAIL rand_accept[%0d]: stable=%0d pc=%h valid=%b, want 1 %h 0", k, acc, o_ifu_pc, o_ifu_valid, m_pc); end
         $display("rand[%0d]: addr=%h inst=%h resp=%0d lat=%0d", k, a, d, rs, lat);
         npc = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
         if ($urandom_range(0, 4) == 0) begin
            npc = npc | 32'(2'($urandom_range(1, 3)));
            m_pc = npc;
            retire(npc);
            checks++;
            if (o_ifu_valid !== 1'b1 || o_ifu_fault !== 1'b1 || o_ifu_inst !== 32'h0 || o_ifu_pc !== npc || o_ifu_arvalid !== 1'b0)
               begin errors++; $display("FAIL rand_misaligned[%0d]: valid=%b fault=%b inst=%h pc=%h arvalid=%b, want 1 1 0 %h 0",
                                        k, o_ifu_valid, o_ifu_fault, o_ifu_inst, o_ifu_pc, o_ifu_arvalid, npc); end
            accept(0, 1'b0, acc);
            npc = npc & 32'hFFFF_FFFC;
         end
         m_pc = npc;
         retire(npc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ar_stall();
      test_out_stall();
      test_err_resp();
      test_timeout();
      test_misaligned();
      test_reset_midwait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute backstop so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
